// File: rtl/vga_pixel_write_buffer.sv
// Filters sprite pixels to the visible screen, queues them and writes them into the framebuffer; also runs a full-screen clear.
// Latency: pixel sampled into an empty queue is written one clock later; no backpressure, overflow pixels are dropped and counted.
module vga_pixel_write_buffer #(
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 15,
  parameter int COLOR_W    = 3
) (
  input  logic               clock_50,
  input  logic               resetn,
  input  logic               vga_plot,
  input  logic [7:0]         vga_x,
  input  logic [7:0]         vga_y,
  input  logic [COLOR_W-1:0] vga_color,
  input  logic               clear_req,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  output logic               clear_busy,
  output logic [7:0]         drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] color;
  } pix_t;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  pix_t               fifo_mem [FIFO_DEPTH];
  pix_t               in_pix, head_pix;
  logic [ADDR_W-1:0]  sweep_q;
  logic [COLOR_W-1:0] clear_col_q;
  logic               on_screen, fifo_empty, fifo_full, pop, push, drop;

  assign on_screen = vga_plot && (int'(vga_x) < SCREEN_W) && (int'(vga_y) < SCREEN_H);

  assign in_pix.addr  = ADDR_W'(vga_y) * ADDR_W'(SCREEN_W) + ADDR_W'(vga_x);
  assign in_pix.color = vga_color;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                      (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);

  assign pop      = (state_q == IDLE) && !fifo_empty;
  assign push     = on_screen && (!fifo_full || pop);
  assign drop     = on_screen && fifo_full && !pop;
  assign head_pix = fifo_mem[rd_ptr[PTR_W-2:0]];

  assign clear_busy = (state_q == CLEAR);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clear_req) state_d = CLEAR;
      CLEAR:   if (sweep_q == LAST_ADDR) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_50 or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clock_50) begin
    if (push) fifo_mem[wr_ptr[PTR_W-2:0]] <= in_pix;
  end

  always_ff @(posedge clock_50 or negedge resetn) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      sweep_q     <= '0;
      clear_col_q <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
      drop_count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (state_q == IDLE && clear_req) begin
        sweep_q     <= '0;
        clear_col_q <= clear_color;
      end

      if (state_q == CLEAR) begin
        mem_we   <= 1'b1;
        mem_addr <= sweep_q;
        mem_data <= clear_col_q;
        sweep_q  <= sweep_q + 1'b1;
      end else if (pop) begin
        mem_we   <= 1'b1;
        mem_addr <= head_pix.addr;
        mem_data <= head_pix.color;
      end else begin
        mem_we   <= 1'b0;
      end

      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_pixel_write_buffer.sv
// Bench for vga_pixel_write_buffer: vector table, queue-based write model, clear sweep and reset sequences.
module tb_vga_pixel_write_buffer;

  logic        clock_50 = 1'b0;
  logic        resetn;
  logic        vga_plot;
  logic [7:0]  vga_x, vga_y;
  logic [2:0]  vga_color, clear_color;
  logic        clear_req;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        clear_busy;
  logic [7:0]  drop_count;

  vga_pixel_write_buffer dut (
    .clock_50(clock_50), .resetn(resetn), .vga_plot(vga_plot), .vga_x(vga_x),
    .vga_y(vga_y), .vga_color(vga_color), .clear_req(clear_req),
    .clear_color(clear_color), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .clear_busy(clear_busy), .drop_count(drop_count)
  );

  always #5 clock_50 = ~clock_50;

  typedef struct {
    bit plot; int x; int y; int col;
    bit exp_we; int exp_addr; int exp_data;
  } vec_t;

  typedef struct { int addr; int col; int due; } exp_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   track = 0;
  exp_t exp_q[$];
  vec_t vt[9];

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Expected writes: every on-screen pixel, in order, two bench steps after it is driven.
  task automatic check_model();
    exp_t e;
    if (mem_we) begin
      if (exp_q.size() == 0) chk("spurious_write", int'(mem_we), 0);
      else begin
        e = exp_q.pop_front();
        chk("model_addr", int'(mem_addr), e.addr);
        chk("model_data", int'(mem_data), e.col);
        chk("model_latency", cyc, e.due);
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      chk("missing_write", int'(mem_we), 1);
      e = exp_q.pop_front();
    end
  endtask

  task automatic step();
    @(posedge clock_50);
    #1;
    cyc++;
    if (track) check_model();
  endtask

  task automatic drive_pix(input bit p, input int x, input int y, input int c);
    vga_plot  = p;
    vga_x     = 8'(x);
    vga_y     = 8'(y);
    vga_color = 3'(c);
    if (track && p && x < 160 && y < 120)
      exp_q.push_back('{y * 160 + x, c, cyc + 2});
  endtask

  task automatic run_clear(input int color, input bit inject);
    int   bc = 0, wc = 0, bad = 0, i = 0;
    exp_t acc[$];
    clear_color = 3'(color);
    clear_req   = 1'b1;
    do begin
      step();
      i++;
      if (clear_busy) bc++;
      if (mem_we) begin
        if (int'(mem_addr) != wc || int'(mem_data) != color) bad++;
        wc++;
      end
      if (i == 1) begin
        clear_req   = 1'b0;
        clear_color = 3'(~color);
      end
      if (inject && i >= 100 && i < 110) begin
        int x = $urandom_range(0, 159), y = $urandom_range(0, 119), c = $urandom_range(0, 7);
        drive_pix(1'b1, x, y, c);
        if (acc.size() < 8) acc.push_back('{y * 160 + x, c, 0});
      end
      if (inject && i == 110) drive_pix(1'b0, 0, 0, 0);
      if (inject && i == 300) clear_req = 1'b1;
      if (inject && i == 301) clear_req = 1'b0;
    end while (clear_busy && i < 20000);
    chk("clear_timeout", int'(i < 20000), 1);
    chk("clear_busy_cycles", bc, 19200);
    chk("clear_writes", wc, 19200);
    chk("clear_bad_writes", bad, 0);
    for (int k = 0; k < acc.size(); k++) begin
      step();
      chk("drain_we", int'(mem_we), 1);
      chk("drain_addr", int'(mem_addr), acc[k].addr);
      chk("drain_data", int'(mem_data), acc[k].col);
    end
    step();
    chk("post_clear_idle", int'(mem_we), 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b1,   3,   2, 6, 1'b1,   323, 6};
    vt[1] = '{1'b1, 160,   5, 1, 1'b0,     0, 0};
    vt[2] = '{1'b1,  10, 120, 2, 1'b0,     0, 0};
    vt[3] = '{1'b1,   0,   0, 5, 1'b1,     0, 5};
    vt[4] = '{1'b1, 159, 119, 7, 1'b1, 19199, 7};
    vt[5] = '{1'b1, 159,   0, 3, 1'b1,   159, 3};
    vt[6] = '{1'b1,   0, 119, 4, 1'b1, 19040, 4};
    vt[7] = '{1'b0,  20,  20, 1, 1'b0,     0, 0};
    vt[8] = '{1'b1, 255, 255, 1, 1'b0,     0, 0};

    resetn = 1'b0; vga_plot = 0; vga_x = 0; vga_y = 0; vga_color = 0;
    clear_req = 0; clear_color = 0;
    #12;
    chk("rst_we", int'(mem_we), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_data", int'(mem_data), 0);
    chk("rst_busy", int'(clear_busy), 0);
    chk("rst_drop", int'(drop_count), 0);
    #11 resetn = 1'b1;
    step();
    chk("idle_after_reset", int'(mem_we), 0);

    foreach (vt[i]) begin
      drive_pix(vt[i].plot, vt[i].x, vt[i].y, vt[i].col);
      step();
      drive_pix(1'b0, 0, 0, 0);
      step();
      chk("vec_we", int'(mem_we), int'(vt[i].exp_we));
      if (vt[i].exp_we) begin
        chk("vec_addr", int'(mem_addr), vt[i].exp_addr);
        chk("vec_data", int'(mem_data), vt[i].exp_data);
      end
      step();
      chk("vec_we_pulse", int'(mem_we), 0);
    end
    chk("vec_drop", int'(drop_count), 0);

    // Make sure mem_data is non-zero before the black clear.
    drive_pix(1'b1, 1, 1, 6); step(); drive_pix(1'b0, 0, 0, 0); step(); step();
    run_clear(0, 1'b0);

    track = 1'b1;
    for (int i = 0; i < 25; i++) begin
      drive_pix(1'b1, $urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 7));
      step();
    end
    drive_pix(1'b0, 0, 0, 0);
    step(); step(); step();
    chk("stream_q_empty", exp_q.size(), 0);

    for (int i = 0; i < 300; i++) begin
      drive_pix($urandom_range(0, 3) != 0, $urandom_range(0, 175),
                $urandom_range(0, 135), $urandom_range(0, 7));
      step();
    end
    drive_pix(1'b0, 0, 0, 0);
    step(); step(); step();
    chk("random_q_empty", exp_q.size(), 0);
    chk("random_drop", int'(drop_count), 0);
    track = 1'b0;

    run_clear(5, 1'b1);
    chk("overflow_drop", int'(drop_count), 2);

    begin
      bit hit = 0;
      clear_color = 3'd2;
      clear_req   = 1'b1;
      step();
      clear_req = 1'b0;
      for (int i = 0; i < 1000 && !hit; i++) begin
        drive_pix(1'b1, $urandom_range(0, 159), $urandom_range(0, 119), 1);
        step();
        if (mem_we && mem_addr == 15'd500) hit = 1;
      end
      chk("reached_500", int'(mem_addr), 500);
      chk("drop_saturated", int'(drop_count), 255);
      resetn = 1'b0;
      #1;
      chk("midreset_we", int'(mem_we), 0);
      chk("midreset_busy", int'(clear_busy), 0);
      chk("midreset_drop", int'(drop_count), 0);
      chk("midreset_addr", int'(mem_addr), 0);
      drive_pix(1'b0, 0, 0, 0);
      step(); step();
      resetn = 1'b1;
      begin
        int wcount = 0;
        for (int i = 0; i < 20; i++) begin
          step();
          if (mem_we || clear_busy) wcount++;
        end
        chk("post_reset_quiet", wcount, 0);
      end
      track = 1'b1;
      drive_pix(1'b1, 7, 7, 3);
      step();
      drive_pix(1'b0, 0, 0, 0);
      step(); step(); step();
      chk("post_reset_pixel", exp_q.size(), 0);
      chk("post_reset_drop", int'(drop_count), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
